// File: rtl/video_format_lock.sv
// ---------------------------------------------------------------------------
// video_format_lock
//
// Qualifies the per-frame (hres, vres) measurement of the incoming video and
// publishes a stable "locked" format to the scaler / HDMI timing logic.
// hres comes from the upstream horizontal measurement stage. vres is the
// number of active lines counted here between frame events. A frame event is
// the registered falling edge of the negative-polarity vsync.
//
// Parameters:
//   LOCK_FRAMES    consecutive identical valid frames needed to lock (1..15)
//   TIMEOUT_CYCLES vd_clk cycles without a frame event before no_signal
//
// Ports:
//   vd_clk      pixel clock
//   rst_n       asynchronous active-low reset
//   vd_vs       vertical sync, negative polarity
//   vd_de       data enable, active high
//   vd_hres_in  horizontal resolution from upstream, updates once per frame
//   fmt_hres    locked horizontal resolution
//   fmt_vres    locked vertical resolution (active lines)
//   fmt_lock    format stable
//   fmt_chg     one-cycle pulse on every lock / unlock transition
//   no_signal   high while no frame event has been seen for TIMEOUT_CYCLES
//
// Optional feature (macro FMT_IRQ_LATCH_EN):
//   irq_clr     input pulse that clears the sticky interrupt
//   fmt_irq     sticky flag set by fmt_chg; set wins over a same-cycle clear
// ---------------------------------------------------------------------------
module video_format_lock #(
    parameter int          LOCK_FRAMES    = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
    input  logic        vd_clk,
    input  logic        rst_n,
    input  logic        vd_vs,
    input  logic        vd_de,
    input  logic [15:0] vd_hres_in,
    output logic [15:0] fmt_hres,
    output logic [15:0] fmt_vres,
    output logic        fmt_lock,
    output logic        fmt_chg,
    output logic        no_signal
`ifdef FMT_IRQ_LATCH_EN
    ,
    input  logic        irq_clr,
    output logic        fmt_irq
`endif
);

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    state_t      state_q, state_d;
    logic [2:0]  vs_pipe_q, vs_pipe_d;
    logic        de_dly_q, de_dly_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [23:0] timeout_cnt_q, timeout_cnt_d;
    logic [15:0] cand_h_q, cand_h_d;
    logic [15:0] cand_v_q, cand_v_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [15:0] fmt_hres_q, fmt_hres_d;
    logic [15:0] fmt_vres_q, fmt_vres_d;
    logic        fmt_lock_q, fmt_lock_d;
    logic        fmt_chg_q, fmt_chg_d;
    logic        no_signal_q, no_signal_d;

    logic        frame_evt;
    logic        de_fall;
    logic [15:0] vres_meas;
    logic        meas_ok;
    logic        is_match;
    logic [3:0]  match_inc;
    logic        timeout_hit;

    // Three-stage vsync delay: the frame event lands late enough that the
    // upstream hres value for the finished frame is already stable.
    always_comb begin
        vs_pipe_d = {vs_pipe_q[1:0], vd_vs};
        de_dly_d  = vd_de;
        frame_evt = vs_pipe_q[2] & ~vs_pipe_q[1];
        de_fall   = de_dly_q & ~vd_de;
    end

    // Active-line counter. A line ending in the same cycle as the frame
    // event belongs to the new frame, hence the reload with de_fall.
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (frame_evt) begin
            line_cnt_d = {15'd0, de_fall};
        end else if (de_fall && (line_cnt_q != 16'hFFFF)) begin
            line_cnt_d = line_cnt_q + 16'd1;
        end
        vres_meas = line_cnt_q;
        meas_ok   = (vd_hres_in != 16'd0) && (vres_meas != 16'd0) &&
                    (vres_meas != 16'hFFFF);
    end

    // Loss-of-signal counter: saturates at TIMEOUT_CYCLES so the timeout
    // fires exactly once per outage.
    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        timeout_hit   = 1'b0;
        if (frame_evt) begin
            timeout_cnt_d = 24'd0;
        end else if (timeout_cnt_q != TIMEOUT_CYCLES) begin
            timeout_cnt_d = timeout_cnt_q + 24'd1;
            timeout_hit   = (timeout_cnt_d == TIMEOUT_CYCLES);
        end
    end

    // Lock FSM. A frame event takes priority over a coinciding timeout.
    // In LOCKED the candidate registers still hold the locked format, so
    // is_match compares against the published values.
    always_comb begin
        state_d     = state_q;
        cand_h_d    = cand_h_q;
        cand_v_d    = cand_v_q;
        match_cnt_d = match_cnt_q;
        fmt_hres_d  = fmt_hres_q;
        fmt_vres_d  = fmt_vres_q;
        fmt_lock_d  = fmt_lock_q;
        fmt_chg_d   = 1'b0;
        no_signal_d = no_signal_q;
        match_inc   = match_cnt_q + 4'd1;
        is_match    = meas_ok && (vd_hres_in == cand_h_q) &&
                      (vres_meas == cand_v_q);

        if (frame_evt) begin
            no_signal_d = 1'b0;
            case (state_q)
                SEARCH: begin
                    if (meas_ok) begin
                        cand_h_d    = vd_hres_in;
                        cand_v_d    = vres_meas;
                        match_cnt_d = 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state_d    = LOCKED;
                            fmt_hres_d = vd_hres_in;
                            fmt_vres_d = vres_meas;
                            fmt_lock_d = 1'b1;
                            fmt_chg_d  = 1'b1;
                        end else begin
                            state_d = TRAIN;
                        end
                    end
                end
                TRAIN: begin
                    if (!meas_ok) begin
                        state_d = SEARCH;
                    end else if (is_match) begin
                        match_cnt_d = match_inc;
                        if (match_inc >= LOCK_N) begin
                            state_d    = LOCKED;
                            fmt_hres_d = cand_h_q;
                            fmt_vres_d = cand_v_q;
                            fmt_lock_d = 1'b1;
                            fmt_chg_d  = 1'b1;
                        end
                    end else begin
                        cand_h_d    = vd_hres_in;
                        cand_v_d    = vres_meas;
                        match_cnt_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!is_match) begin
                        fmt_lock_d = 1'b0;
                        fmt_chg_d  = 1'b1;
                        if (!meas_ok) begin
                            state_d = SEARCH;
                        end else begin
                            state_d     = TRAIN;
                            cand_h_d    = vd_hres_in;
                            cand_v_d    = vres_meas;
                            match_cnt_d = 4'd1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else if (timeout_hit) begin
            state_d     = SEARCH;
            no_signal_d = 1'b1;
            fmt_chg_d   = fmt_lock_q;
            fmt_lock_d  = 1'b0;
        end
    end

    always_ff @(posedge vd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            vs_pipe_q     <= 3'b000;
            de_dly_q      <= 1'b0;
            line_cnt_q    <= 16'd0;
            timeout_cnt_q <= 24'd0;
            cand_h_q      <= 16'd0;
            cand_v_q      <= 16'd0;
            match_cnt_q   <= 4'd0;
            fmt_hres_q    <= 16'd0;
            fmt_vres_q    <= 16'd0;
            fmt_lock_q    <= 1'b0;
            fmt_chg_q     <= 1'b0;
            no_signal_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            vs_pipe_q     <= vs_pipe_d;
            de_dly_q      <= de_dly_d;
            line_cnt_q    <= line_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            cand_h_q      <= cand_h_d;
            cand_v_q      <= cand_v_d;
            match_cnt_q   <= match_cnt_d;
            fmt_hres_q    <= fmt_hres_d;
            fmt_vres_q    <= fmt_vres_d;
            fmt_lock_q    <= fmt_lock_d;
            fmt_chg_q     <= fmt_chg_d;
            no_signal_q   <= no_signal_d;
        end
    end

    assign fmt_hres  = fmt_hres_q;
    assign fmt_vres  = fmt_vres_q;
    assign fmt_lock  = fmt_lock_q;
    assign fmt_chg   = fmt_chg_q;
    assign no_signal = no_signal_q;

`ifdef FMT_IRQ_LATCH_EN
    logic fmt_irq_q, fmt_irq_d;

    // Sticky interrupt: set is applied last so it wins over a clear.
    always_comb begin
        fmt_irq_d = fmt_irq_q;
        if (irq_clr) begin
            fmt_irq_d = 1'b0;
        end
        if (fmt_chg_q) begin
            fmt_irq_d = 1'b1;
        end
    end

    always_ff @(posedge vd_clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_irq_q <= 1'b0;
        end else begin
            fmt_irq_q <= fmt_irq_d;
        end
    end

    assign fmt_irq = fmt_irq_q;
`endif

endmodule

// File: tb/tb_video_format_lock.sv
// ---------------------------------------------------------------------------
// tb_video_format_lock
//
// Drives whole frames (n active lines, then a vsync pulse carrying the hres
// of the finished frame) and compares the published format against a
// frame-level reference: the format is locked whenever the trailing run of
// identical valid (hres, vres) measurements is at least LOCK frames long.
// The loss-of-signal timeout must exceed the longest frame driven here
// (720 lines at two cycles per line), so it is set to 2000 cycles.
// ---------------------------------------------------------------------------
module tb_video_format_lock;

    localparam int          LOCK = 3;
    localparam logic [23:0] TO   = 24'd2000;

    logic        vd_clk;
    logic        rst_n;
    logic        vd_vs;
    logic        vd_de;
    logic [15:0] vd_hres_in;
    logic [15:0] fmt_hres;
    logic [15:0] fmt_vres;
    logic        fmt_lock;
    logic        fmt_chg;
    logic        no_signal;
`ifdef FMT_IRQ_LATCH_EN
    logic        irq_clr;
    logic        fmt_irq;
    logic        exp_irq;
`endif

    int          vec_cnt       = 0;
    int          err_cnt       = 0;
    int          tick_cnt      = 0;
    int          chg_seen      = 0;
    int          exp_chg_total = 0;
    int          last_fe_tick  = 0;

    int          run_len;
    logic [15:0] run_h;
    logic [15:0] run_v;
    logic [15:0] exp_h;
    logic [15:0] exp_v;
    logic        exp_lock;
    logic        exp_chg;
    logic        exp_ns;

    video_format_lock #(
        .LOCK_FRAMES    (LOCK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .vd_clk     (vd_clk),
        .rst_n      (rst_n),
        .vd_vs      (vd_vs),
        .vd_de      (vd_de),
        .vd_hres_in (vd_hres_in),
        .fmt_hres   (fmt_hres),
        .fmt_vres   (fmt_vres),
        .fmt_lock   (fmt_lock),
        .fmt_chg    (fmt_chg),
        .no_signal  (no_signal)
`ifdef FMT_IRQ_LATCH_EN
        ,
        .irq_clr    (irq_clr),
        .fmt_irq    (fmt_irq)
`endif
    );

    initial begin
        vd_clk = 1'b0;
        forever #5 vd_clk = ~vd_clk;
    end

    // Counts every cycle fmt_chg is seen high, anywhere in the run.
    always @(negedge vd_clk) begin
        if (fmt_chg === 1'b1) begin
            chg_seen++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge vd_clk);
        tick_cnt++;
    endtask

    task automatic modelReset();
        run_len  = 0;
        run_h    = 16'd0;
        run_v    = 16'd0;
        exp_h    = 16'd0;
        exp_v    = 16'd0;
        exp_lock = 1'b0;
        exp_chg  = 1'b0;
        exp_ns   = 1'b1;
`ifdef FMT_IRQ_LATCH_EN
        exp_irq  = 1'b0;
`endif
    endtask

    task automatic modelFrame(input logic [15:0] h, input int n);
        logic valid;
        logic new_lock;
        valid = (h != 16'd0) && (n != 0) && (n != 65535);
        if (!valid) begin
            run_len = 0;
        end else if (run_len > 0 && h == run_h && n[15:0] == run_v) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_len = 1;
            run_h   = h;
            run_v   = n[15:0];
        end
        new_lock = (run_len >= LOCK);
        exp_chg  = (new_lock != exp_lock);
        if (new_lock && !exp_lock) begin
            exp_h = h;
            exp_v = n[15:0];
        end
        exp_lock = new_lock;
        exp_ns   = 1'b0;
        if (exp_chg) begin
            exp_chg_total++;
`ifdef FMT_IRQ_LATCH_EN
            exp_irq = 1'b1;
`endif
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_lock"}, fmt_lock, 0);
        checkOutput({tag, "_hres"}, fmt_hres, 0);
        checkOutput({tag, "_vres"}, fmt_vres, 0);
        checkOutput({tag, "_chg"}, fmt_chg, 0);
        checkOutput({tag, "_nosig"}, no_signal, 1);
`ifdef FMT_IRQ_LATCH_EN
        checkOutput({tag, "_irq"}, fmt_irq, 0);
`endif
    endtask

    // One frame: n active lines, front porch, then a vsync pulse with the
    // frame's hres presented; outputs are checked around the frame event.
    task automatic applyStimulus(input logic [15:0] h, input int n);
        for (int i = 0; i < n; i++) begin
            vd_de = 1'b1;
            tick();
            vd_de = 1'b0;
            tick();
        end
        tick();
        tick();
        vd_hres_in = h;
        vd_vs      = 1'b0;
        tick();
        tick();
        checkOutput("pre_fe_lock", fmt_lock, exp_lock);
        checkOutput("pre_fe_chg", fmt_chg, 0);
        modelFrame(h, n);
        tick();
        last_fe_tick = tick_cnt;
        checkOutput("fe_lock", fmt_lock, exp_lock);
        checkOutput("fe_hres", fmt_hres, exp_h);
        checkOutput("fe_vres", fmt_vres, exp_v);
        checkOutput("fe_chg", fmt_chg, exp_chg);
        checkOutput("fe_nosig", no_signal, exp_ns);
        vd_vs = 1'b1;
        tick();
        checkOutput("post_fe_chg", fmt_chg, 0);
`ifdef FMT_IRQ_LATCH_EN
        checkOutput("post_fe_irq", fmt_irq, exp_irq);
`endif
        tick();
    endtask

    initial begin
        logic [15:0] ph;
        int          pn;
        int          r;

        rst_n      = 1'b0;
        vd_vs      = 1'b1;
        vd_de      = 1'b0;
        vd_hres_in = 16'd0;
`ifdef FMT_IRQ_LATCH_EN
        irq_clr    = 1'b0;
`endif
        modelReset();
        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] stable 1280x720 lock");
        for (int i = 0; i < 3; i++) applyStimulus(16'd1280, 720);

        $display("[TB] 719-line frame while locked, then relock");
        for (int i = 0; i < 4; i++) applyStimulus(16'd1280, 719);

        $display("[TB] switch to 640x480");
        for (int i = 0; i < 3; i++) applyStimulus(16'd640, 480);

        $display("[TB] zero hres during TRAIN");
        applyStimulus(16'd320, 50);
        applyStimulus(16'd0, 50);
        for (int i = 0; i < 3; i++) applyStimulus(16'd320, 50);

        $display("[TB] loss of signal while locked");
        while (tick_cnt < last_fe_tick + int'(TO) - 1) tick();
        checkOutput("to_before_nosig", no_signal, 0);
        checkOutput("to_before_lock", fmt_lock, 1);
        tick();
        checkOutput("to_nosig", no_signal, 1);
        checkOutput("to_lock", fmt_lock, 0);
        checkOutput("to_chg", fmt_chg, 1);
        exp_chg_total++;
        run_len  = 0;
        exp_lock = 1'b0;
        exp_ns   = 1'b1;
`ifdef FMT_IRQ_LATCH_EN
        exp_irq  = 1'b1;
`endif
        tick();
        checkOutput("to_post_chg", fmt_chg, 0);
        checkOutput("to_hold_hres", fmt_hres, exp_h);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("to_hold_nosig", no_signal, 1);
        for (int i = 0; i < 3; i++) applyStimulus(16'd320, 50);

        $display("[TB] reset in the middle of TRAIN");
        applyStimulus(16'd640, 50);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkReset("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkReset("after_reset");

`ifdef FMT_IRQ_LATCH_EN
        for (int i = 0; i < 3; i++) applyStimulus(16'd640, 50);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        exp_irq = 1'b0;
        checkOutput("irq_clear", fmt_irq, 0);
`endif

        $display("[TB] randomized frames");
        ph = 16'd320;
        pn = 3;
        for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            if (r >= 6) begin
                if (r == 9) ph = 16'd0;
                else ph = ($urandom_range(0, 1) == 0) ? 16'd320 : 16'd640;
                pn = int'($urandom_range(0, 5));
            end else if (ph == 16'd0) begin
                ph = 16'd640;
            end
            applyStimulus(ph, pn);
        end

        for (int i = 0; i < 4; i++) tick();
        checkOutput("chg_total", chg_seen, exp_chg_total);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
